// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with an optional maximum hold time.
// A rotated copy of the request vector is priority-encoded so that the
// requester just after the last winner always has the highest priority.
// All outputs are registered; there is one dead cycle between winners.
module rr_arbiter8 #(
  parameter int HOLD_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_code,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // Last legal hold count before a forced release; unused when MAX_HOLD is 0.
  localparam bit              TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    TIMEOUT_EN ? HOLD_W'(MAX_HOLD - 1) : '0;
  localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

  state_t            state_q;
  logic [2:0]        ptr_q;
  logic [HOLD_W-1:0] hold_q;
  logic [7:0]        grant_q;
  logic [2:0]        code_q;
  logic              valid_q;
  logic              timeout_q;

  logic [15:0]       req_dbl;
  logic [7:0]        req_rot;
  logic [2:0]        win_off;
  logic [2:0]        win_d;

  // Rotate requests so index 0 of req_rot corresponds to ptr, then take the
  // lowest set bit; adding ptr back (mod 8) gives the winner's real index.
  always_comb begin
    req_dbl = {req, req} >> ptr_q;
    req_rot = req_dbl[7:0];
    win_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_off = 3'(i);
      end
    end
    win_d = ptr_q + win_off;
  end

  // Arbitration state machine with registered outputs and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      hold_q    <= '0;
      grant_q   <= 8'd0;
      code_q    <= 3'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req != 8'd0) begin
            grant_q <= 8'd1 << win_d;
            code_q  <= win_d;
            valid_q <= 1'b1;
            hold_q  <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!req[code_q]) begin
            // Voluntary release: winner becomes lowest priority next round.
            grant_q <= 8'd0;
            code_q  <= 3'd0;
            valid_q <= 1'b0;
            ptr_q   <= code_q + 3'd1;
            state_q <= IDLE;
          end else if (TIMEOUT_EN && (hold_q == HOLD_LAST)) begin
            // Forced release after MAX_HOLD visible cycles.
            grant_q   <= 8'd0;
            code_q    <= 3'd0;
            valid_q   <= 1'b0;
            ptr_q     <= code_q + 3'd1;
            state_q   <= IDLE;
            timeout_q <= 1'b1;
          end else if (hold_q != HOLD_SAT) begin
            // Saturate so an unlimited hold never wraps into a false timeout.
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_code  = code_q;
  assign grant_valid = valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: two instances (MAX_HOLD=4 and MAX_HOLD=0) share the
// same stimulus; a behavioural model is compared every cycle, and directed
// literal expectations pin the model's behaviour.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = 8'd0;

  logic [7:0] a_grant, b_grant;
  logic [2:0] a_code, b_code;
  logic       a_valid, b_valid, a_to, b_to;

  always #5 clk = ~clk;

  rr_arbiter8 #(.HOLD_W(8), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(a_grant), .grant_code(a_code), .grant_valid(a_valid), .timeout(a_to)
  );

  rr_arbiter8 #(.HOLD_W(8), .MAX_HOLD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(b_grant), .grant_code(b_code), .grant_valid(b_valid), .timeout(b_to)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: per instance, whether a grant is held, who holds it,
  // how many cycles it has been visible, the next-priority index, timeout.
  bit m_busy[2];
  int m_w[2];
  int m_n[2];
  int m_ptr[2];
  bit m_to[2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      m_w[k]    = 0;
      m_n[k]    = 0;
      m_ptr[k]  = 0;
      m_to[k]   = 1'b0;
    end
  endfunction

  function automatic void model_step(input int k, input int max_hold, input logic [7:0] r);
    int idx;
    m_to[k] = 1'b0;
    if (!m_busy[k]) begin
      if (r != 8'd0) begin
        for (int off = 7; off >= 0; off--) begin
          idx = (m_ptr[k] + off) % 8;
          if (r[idx]) m_w[k] = idx;
        end
        m_busy[k] = 1'b1;
        m_n[k]    = 1;
      end
    end else if (!r[m_w[k]]) begin
      m_busy[k] = 1'b0;
      m_ptr[k]  = (m_w[k] + 1) % 8;
    end else if (max_hold != 0 && m_n[k] == max_hold) begin
      m_busy[k] = 1'b0;
      m_ptr[k]  = (m_w[k] + 1) % 8;
      m_to[k]   = 1'b1;
    end else begin
      m_n[k] = m_n[k] + 1;
    end
  endfunction

  always @(negedge rst_n) model_reset();

  // Per-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    if (rst_n) begin
      model_step(0, 4, req);
      model_step(1, 0, req);
    end
    #1;
    chk("a_grant", int'(a_grant), m_busy[0] ? (1 << m_w[0]) : 0);
    chk("a_code",  int'(a_code),  m_busy[0] ? m_w[0] : 0);
    chk("a_valid", int'(a_valid), int'(m_busy[0]));
    chk("a_timeout", int'(a_to),  int'(m_to[0]));
    chk("b_grant", int'(b_grant), m_busy[1] ? (1 << m_w[1]) : 0);
    chk("b_code",  int'(b_code),  m_busy[1] ? m_w[1] : 0);
    chk("b_valid", int'(b_valid), int'(m_busy[1]));
    chk("b_timeout", int'(b_to),  int'(m_to[1]));
  end

  // Window monitor used by directed checks: grant starts and pulse counts.
  bit win = 1'b0;
  int a_starts[$];
  bit a_prev = 1'b0;
  int cnt_av, cnt_ato, cnt_bv, cnt_bto;

  always @(posedge clk) begin
    #1;
    if (win) begin
      if (a_valid && !a_prev) a_starts.push_back(int'(a_code));
      cnt_av  += int'(a_valid);
      cnt_ato += int'(a_to);
      cnt_bv  += int'(b_valid);
      cnt_bto += int'(b_to);
    end
    a_prev = a_valid;
  end

  task automatic clear_window();
    a_starts.delete();
    cnt_av = 0; cnt_ato = 0; cnt_bv = 0; cnt_bto = 0;
  endtask

  initial begin
    #1 rst_n = 1'b0;

    // Reset held for 3 cycles, then idle with no requests.
    repeat (3) @(negedge clk);
    chk("rst_a_grant", int'(a_grant), 0);
    chk("rst_a_valid", int'(a_valid), 0);
    chk("rst_b_grant", int'(b_grant), 0);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_a_grant", int'(a_grant), 0);
      chk("idle_a_code", int'(a_code), 0);
      chk("idle_a_valid", int'(a_valid), 0);
      chk("idle_a_timeout", int'(a_to), 0);
    end

    // Single requesters 0..7, each held 3 cycles then dropped.
    for (int i = 0; i < 8; i++) begin
      req = 8'(1 << i);
      @(negedge clk);
      chk("single_code", int'(a_code), i);
      chk("single_grant", int'(a_grant), 1 << i);
      repeat (2) @(negedge clk);
      chk("single_held", int'(a_grant), 1 << i);
      req = 8'd0;
      @(negedge clk);
      chk("single_release", int'(a_valid), 0);
    end

    // Fairness with all requesting: 0..7,0, each 4 cycles plus timeout.
    clear_window();
    win = 1'b1;
    req = 8'hFF;
    repeat (45) @(negedge clk);
    win = 1'b0;
    req = 8'd0;
    chk("rr_grant_count", a_starts.size(), 9);
    for (int j = 0; j < a_starts.size() && j < 9; j++) begin
      chk("rr_order", a_starts[j], j % 8);
    end
    chk("rr_valid_cycles", cnt_av, 36);
    chk("rr_timeouts", cnt_ato, 9);
    chk("nohold_valid_cycles", cnt_bv, 45);
    chk("nohold_timeouts", cnt_bto, 0);
    repeat (2) @(negedge clk);

    // Rotation and wrap: grant 6, release, then 7 -> 0 -> 1.
    req = 8'h40;
    @(negedge clk);
    chk("wrap_first", int'(a_code), 6);
    req = 8'd0;
    repeat (2) @(negedge clk);
    clear_window();
    win = 1'b1;
    req = 8'b1000_0011;
    repeat (13) @(negedge clk);
    win = 1'b0;
    req = 8'd0;
    chk("wrap_count", a_starts.size(), 3);
    if (a_starts.size() == 3) begin
      chk("wrap_w0", a_starts[0], 7);
      chk("wrap_w1", a_starts[1], 0);
      chk("wrap_w2", a_starts[2], 1);
    end
    repeat (3) @(negedge clk);

    // Release on the same edge a timeout would have fired.
    req = 8'h08;
    repeat (4) @(negedge clk);
    chk("bound_held", int'(a_grant), 8'h08);
    chk("bound_no_early_to", int'(a_to), 0);
    req = 8'd0;
    @(negedge clk);
    chk("bound_release", int'(a_grant), 0);
    chk("bound_timeout", int'(a_to), 0);
    repeat (2) @(negedge clk);

    // Unlimited hold: 300 cycles, never revoked.
    clear_window();
    win = 1'b1;
    req = 8'h04;
    repeat (300) @(negedge clk);
    win = 1'b0;
    chk("long_valid_cycles", cnt_bv, 300);
    chk("long_timeouts", cnt_bto, 0);
    chk("long_grant", int'(b_grant), 8'h04);
    req = 8'd0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a grant.
    req = 8'h20;
    @(negedge clk);
    chk("mid_grant", int'(a_grant), 8'h20);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_a_grant", int'(a_grant), 0);
    chk("mid_rst_a_code", int'(a_code), 0);
    chk("mid_rst_a_valid", int'(a_valid), 0);
    chk("mid_rst_a_timeout", int'(a_to), 0);
    chk("mid_rst_b_grant", int'(b_grant), 0);
    chk("mid_rst_b_valid", int'(b_valid), 0);
    @(negedge clk);
    req   = 8'hFF;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_a_code", int'(a_code), 0);
    chk("post_rst_a_grant", int'(a_grant), 1);
    chk("post_rst_b_grant", int'(b_grant), 1);
    req = 8'd0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Internally priority-encodes a rotated request vector, so it also sequences the 8-to-3 encoding path.
- Produces a one-hot grant plus the 3-bit binary index of the granted requester.
- Sits between requester blocks and a shared datapath. Enforces fairness and an optional maximum hold time.

Parameters:
- HOLD_W, 8, width of the hold counter.
- MAX_HOLD, 16, maximum consecutive grant cycles per winner. 0 disables the timeout. Must be < 2^HOLD_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request lines; bit i = requester i. Level-held while the requester wants or uses the resource.
- grant  output  8  one-hot grant; all zero when no grant is active.
- grant_code  output  3  binary index of the granted requester. Valid only when grant_valid = 1, otherwise 0.
- grant_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked by MAX_HOLD.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - grant = 0, grant_code = 0, grant_valid = 0, timeout = 0.
  - State = IDLE, rotation pointer ptr = 0, hold_cnt = 0.
  - Effect is immediate, including mid-grant. After rst_n rises, the first decision happens on the next rising edge.
- States: IDLE, GRANT. All outputs are registered.
- IDLE:
  - If req != 0 at a rising edge, select the winner w: the first index scanning ptr, ptr+1, …, 7, 0, …, ptr-1 (mod 8) with req[w] = 1.
  - On that edge: grant <= 1<<w, grant_code <= w, grant_valid <= 1, hold_cnt <= 0, state <= GRANT.
  - Latency from a req sampled high in IDLE to grant high is exactly 1 cycle.
  - If req = 0, remain in IDLE with outputs 0.
- GRANT (winner w held):
  - Release: if req[w] = 0 at an edge, then grant, grant_code and grant_valid go to 0, ptr <= (w+1) mod 8, state <= IDLE. timeout stays 0.
  - Timeout: else if MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1, perform the same release and additionally set timeout <= 1 for exactly one cycle.
  - Else: hold_cnt <= hold_cnt + 1 and the grant stays unchanged. Changes on other req bits are ignored.
  - A grant is therefore visible for at most MAX_HOLD cycles.
- After any release there is always at least one IDLE cycle with grant = 0 (one dead cycle between winners). Arbitration then resumes from the new ptr.
- A released requester that still holds req high gets lowest priority next round.
- Wrap: w = 7 gives ptr = 0.
- Simultaneous release and timeout on the same edge: release wins, so timeout = 0.
- Outside reset, timeout is cleared on every edge except the timeout edge.
- Invariants:
  - grant is zero or one-hot.
  - grant_valid == (grant != 0).
  - grant_code == index of the set grant bit.
  - hold_cnt never exceeds MAX_HOLD-1; it is wrap-free because MAX_HOLD < 2^HOLD_W.
  - With MAX_HOLD = 0, hold_cnt may saturate at 2^HOLD_W-1 and must not wrap into an effect.
- Starvation bound: with MAX_HOLD > 0, any continuously asserted request is granted within 7·(MAX_HOLD+1)+1 cycles.

Test Plan:
- Reset/idle: rst_n = 0 for 3 cycles, then req = 0 for 5 cycles -> grant = 0, grant_code = 0, grant_valid = 0, timeout = 0 throughout.
- Single requests: req = 8'b00000001 then shifted left one bit per grant cycle (each held 3 cycles, then dropped) -> grant follows 1<<i one cycle after req and grant_code = 0..7 in order. Each grant ends one cycle after req drops.
- Round-robin fairness: req = 8'hFF held constant, MAX_HOLD = 4 -> grants to 0,1,…,7,0. Each lasts 4 cycles, ends with a timeout pulse, and is followed by one idle cycle.
- Rotation/wrap: grant 6 then release, then req = 8'b10000011 -> winner 7, then 0, then 1.
- Boundary: with MAX_HOLD = 4, drop req[w] on the edge where hold_cnt = 3 -> normal release and timeout = 0. With MAX_HOLD = 0, hold req[2] for 300 cycles -> grant is never revoked and timeout is never asserted.
- Reset mid-grant: while grant = 8'b00100000, pull rst_n low between clock edges -> all outputs 0 immediately. After rst_n = 1 with req = 8'hFF, the first grant is to requester 0 (ptr reset).
